// File: rtl/wb_interconnect_nx1_pkg.sv
// Shared types and sizing helpers for the N-to-1 Wishbone interconnect and its arbiter.
package wb_interconnect_nx1_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Index width for an N-entry grant register (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Timeout counter width; a disabled timeout still gets a one-bit counter.
   function automatic int unsigned cnt_width(input int unsigned t);
      return (t == 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/wb_interconnect_nx1_rr_arbiter.sv
// Combinational round-robin select: first requester above last_grant, wrapping.
module wb_rr_arbiter
   import wb_interconnect_nx1_pkg::*;
#(
   parameter int unsigned N = 2,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [IW-1:0] winner,
   output logic          valid
);

   int unsigned idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= N) idx = idx - N;
         if (!valid && req[IW'(idx)]) begin
            valid  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/wb_interconnect_nx1.sv
// N-initiator to single-target Wishbone interconnect with round-robin grant held for
// the whole bus cycle and a per-strobe timeout that errors back to the owner.
module wb_interconnect_nx1
   import wb_interconnect_nx1_pkg::*;
#(
   parameter int unsigned ADR_WIDTH      = 32,
   parameter int unsigned DAT_WIDTH      = 32,
   parameter int unsigned N_INITIATORS   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [N_INITIATORS*ADR_WIDTH-1:0]   t_adr,
   input  logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_w,
   output logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_r,
   input  logic [N_INITIATORS-1:0]             t_cyc,
   output logic [N_INITIATORS-1:0]             t_err,
   input  logic [N_INITIATORS*(DAT_WIDTH/8)-1:0] t_sel,
   input  logic [N_INITIATORS-1:0]             t_stb,
   output logic [N_INITIATORS-1:0]             t_ack,
   input  logic [N_INITIATORS-1:0]             t_we,
   output logic [ADR_WIDTH-1:0]                i_adr,
   output logic [DAT_WIDTH-1:0]                i_dat_w,
   output logic [DAT_WIDTH/8-1:0]              i_sel,
   output logic                                i_we,
   output logic                                i_cyc,
   output logic                                i_stb,
   input  logic [DAT_WIDTH-1:0]                i_dat_r,
   input  logic                                i_ack,
   input  logic                                i_err
);

   localparam int unsigned SW = DAT_WIDTH / 8;
   localparam int unsigned IW = idx_width(N_INITIATORS);
   localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

   state_e          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_grant_q, last_grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   arb_winner;
   logic            arb_valid;
   logic            busy;
   logic            timeout_pend;
   int unsigned     gi;

   wb_rr_arbiter #(.N(N_INITIATORS)) u_arb (
      .req        (t_cyc),
      .last_grant (last_grant_q),
      .winner     (arb_winner),
      .valid      (arb_valid)
   );

   assign busy         = (state_q == ST_BUSY);
   assign gi           = 32'(grant_q);
   assign timeout_pend = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= IW'(N_INITIATORS - 1);
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next state: arbitrate from IDLE or on release; count unanswered strobe cycles.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (arb_valid) begin
               state_d      = ST_BUSY;
               grant_d      = arb_winner;
               last_grant_d = arb_winner;
            end
         end
         ST_BUSY: begin
            if (!t_cyc[grant_q]) begin
               cnt_d = '0;
               if (arb_valid) begin
                  grant_d      = arb_winner;
                  last_grant_d = arb_winner;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (i_ack || i_err || timeout_pend) begin
               cnt_d = '0;
            end else if (i_stb && (TIMEOUT_CYCLES != 0)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request path muxed from the owner; response path steered back to it only.
   always_comb begin
      i_adr   = t_adr[gi*ADR_WIDTH +: ADR_WIDTH];
      i_dat_w = t_dat_w[gi*DAT_WIDTH +: DAT_WIDTH];
      i_sel   = t_sel[gi*SW +: SW];
      i_we    = t_we[grant_q];
      i_cyc   = busy && t_cyc[grant_q];
      i_stb   = busy && t_stb[grant_q] && !timeout_pend;
      t_ack   = '0;
      t_err   = '0;
      if (busy) begin
         t_ack[grant_q] = i_ack;
         t_err[grant_q] = i_err || (timeout_pend && !i_ack);
      end
   end

   assign t_dat_r = {N_INITIATORS{i_dat_r}};

endmodule

// File: tb/tb_wb_interconnect_nx1.sv
// Randomized and directed bench for wb_interconnect_nx1 against a bus-ownership model.
module tb_wb_interconnect_nx1;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int T  = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic [N*AW-1:0] t_adr;
   logic [N*DW-1:0] t_dat_w;
   logic [N*SW-1:0] t_sel;
   logic [N-1:0]    t_cyc, t_stb, t_we;
   logic [DW-1:0]   i_dat_r;
   logic            i_ack, i_err;

   logic [N*DW-1:0] t_dat_r, t_dat_r_z;
   logic [N-1:0]    t_ack, t_err, t_ack_z, t_err_z;
   logic [AW-1:0]   i_adr, i_adr_z;
   logic [DW-1:0]   i_dat_w, i_dat_w_z;
   logic [SW-1:0]   i_sel, i_sel_z;
   logic            i_we, i_cyc, i_stb, i_we_z, i_cyc_z, i_stb_z;

   int n_vec = 0;
   int n_mis = 0;

   wb_interconnect_nx1 #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .N_INITIATORS(N), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
      .t_cyc(t_cyc), .t_err(t_err), .t_sel(t_sel), .t_stb(t_stb), .t_ack(t_ack), .t_we(t_we),
      .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we), .i_cyc(i_cyc),
      .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err));

   wb_interconnect_nx1 #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .N_INITIATORS(N), .TIMEOUT_CYCLES(0)) dut_z (
      .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r_z),
      .t_cyc(t_cyc), .t_err(t_err_z), .t_sel(t_sel), .t_stb(t_stb), .t_ack(t_ack_z), .t_we(t_we),
      .i_adr(i_adr_z), .i_dat_w(i_dat_w_z), .i_sel(i_sel_z), .i_we(i_we_z), .i_cyc(i_cyc_z),
      .i_stb(i_stb_z), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err));

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the bus, who last won, how long the owner's strobe has waited.
   int m_owner, m_g, m_last, m_wait;

   function automatic int pick(input logic [N-1:0] cyc, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (cyc[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clock or posedge reset) begin
      int  w;
      bit  tp;
      if (reset) begin
         m_owner <= -1;
         m_g     <= 0;
         m_last  <= N - 1;
         m_wait  <= 0;
      end else begin
         tp = (T > 0) && (m_wait == T);
         w  = pick(t_cyc, m_last);
         if (m_owner < 0 || !t_cyc[m_g]) begin
            m_wait <= 0;
            if (w >= 0) begin
               m_owner <= w;
               m_g     <= w;
               m_last  <= w;
            end else begin
               m_owner <= -1;
            end
         end else if (i_ack || i_err || tp) begin
            m_wait <= 0;
         end else if (t_stb[m_g]) begin
            m_wait <= m_wait + 1;
         end
      end
   end

   task automatic compare_all();
      int           g;
      bit           busy, tp;
      logic [N-1:0] e_ack, e_err;
      g     = m_g;
      busy  = (m_owner >= 0);
      tp    = (T > 0) && (m_wait == T);
      e_ack = '0;
      e_err = '0;
      if (busy) begin
         e_ack[g] = i_ack;
         e_err[g] = i_err || (tp && !i_ack);
      end
      chk("i_cyc", 64'(i_cyc), 64'(busy && t_cyc[g]));
      chk("i_stb", 64'(i_stb), 64'(busy && t_stb[g] && !tp));
      chk("t_ack", 64'(t_ack), 64'(e_ack));
      chk("t_err", 64'(t_err), 64'(e_err));
      chk("i_adr", 64'(i_adr), 64'(t_adr[g*AW +: AW]));
      chk("i_dat_w", 64'(i_dat_w), 64'(t_dat_w[g*DW +: DW]));
      chk("i_sel", 64'(i_sel), 64'(t_sel[g*SW +: SW]));
      chk("i_we", 64'(i_we), 64'(t_we[g]));
      chk("t_dat_r", 64'(t_dat_r), {i_dat_r, i_dat_r});
   endtask

   always @(negedge clock) compare_all();

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_port(input int p, input logic c, input logic s, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sl);
      t_cyc[p]           = c;
      t_stb[p]           = s;
      t_we[p]            = w;
      t_adr[p*AW +: AW]  = a;
      t_dat_w[p*DW +: DW] = d;
      t_sel[p*SW +: SW]  = sl;
   endtask

   task automatic quiet();
      t_cyc = '0;
      t_stb = '0;
      i_ack = 1'b0;
      i_err = 1'b0;
   endtask

   task automatic pulse_reset();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   localparam logic [AW-1:0] A0 = 32'h1000_0000;
   localparam logic [AW-1:0] A1 = 32'h2000_0000;

   initial begin
      int a0, a1, off, ez, sz;
      bit seen;
      reset   = 1'b1;
      t_adr   = '0;
      t_dat_w = '0;
      t_sel   = '0;
      t_we    = '0;
      i_dat_r = 32'hCAFE_0001;
      quiet();
      #12;
      chk("rst_i_cyc", 64'(i_cyc), 64'd0);
      chk("rst_i_stb", 64'(i_stb), 64'd0);
      chk("rst_t_ack", 64'(t_ack), 64'd0);
      chk("rst_t_err", 64'(t_err), 64'd0);
      tick();
      reset = 1'b0;

      // Single write from initiator 0, target acks immediately.
      tick();
      set_port(0, 1, 1, 1, 32'h2800_0010, 32'hDEAD_BEEF, 4'hF);
      i_ack = 1'b1;
      @(negedge clock);
      chk("w0_latency_i_cyc", 64'(i_cyc), 64'd0);
      tick();
      @(negedge clock);
      chk("w0_i_cyc", 64'(i_cyc), 64'd1);
      chk("w0_i_adr", 64'(i_adr), 64'h2800_0010);
      chk("w0_t_ack", 64'(t_ack), 64'b01);
      tick();
      quiet();
      tick();

      // Contention from reset: 0, then 1 with no bubble, then 0 again.
      pulse_reset();
      set_port(0, 1, 1, 0, A0, 32'h0, 4'h1);
      set_port(1, 1, 1, 0, A1, 32'h0, 4'h2);
      tick();
      @(negedge clock);
      chk("rr_first_adr", 64'(i_adr), 64'(A0));
      chk("rr_first_cyc", 64'(i_cyc), 64'd1);
      tick();
      t_cyc[0] = 1'b0;
      t_stb[0] = 1'b0;
      tick();
      @(negedge clock);
      chk("rr_handover_adr", 64'(i_adr), 64'(A1));
      chk("rr_handover_cyc", 64'(i_cyc), 64'd1);
      t_cyc[0] = 1'b1;
      t_stb[0] = 1'b1;
      tick();
      t_cyc[1] = 1'b0;
      t_stb[1] = 1'b0;
      tick();
      @(negedge clock);
      chk("rr_alternate_adr", 64'(i_adr), 64'(A0));
      tick();
      quiet();
      tick();
      tick();

      // Initiator 1 holds the cycle across four strobes while 0 waits.
      set_port(1, 1, 0, 1, A1, 32'h1111, 4'hF);
      tick();
      set_port(0, 1, 1, 0, A0, 32'h0, 4'hF);
      t_stb[1] = 1'b1;
      i_ack    = 1'b1;
      a0 = 0;
      a1 = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (t_ack[1]) a1++;
         if (t_ack[0]) a0++;
         tick();
      end
      t_stb[1] = 1'b0;
      i_ack    = 1'b0;
      tick();
      t_cyc[1] = 1'b0;
      tick();
      @(negedge clock);
      chk("hold_ack1_count", 64'(a1), 64'd4);
      chk("hold_ack0_count", 64'(a0), 64'd0);
      chk("hold_release_adr", 64'(i_adr), 64'(A0));
      tick();
      quiet();
      tick();
      tick();

      // Timeout: error pulse eight cycles after the strobe is first presented.
      set_port(0, 1, 1, 0, A0, 32'h0, 4'hF);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         if (i_stb) seen = 1'b1;
      end
      chk("to_stb_seen", 64'(seen), 64'd1);
      off = 0;
      for (int k = 1; k <= 20 && off == 0; k++) begin
         @(negedge clock);
         if (t_err != 0) off = k;
      end
      chk("to_offset", 64'(off), 64'd8);
      chk("to_err_vec", 64'(t_err), 64'b01);
      chk("to_stb_low", 64'(i_stb), 64'd0);
      @(negedge clock);
      chk("to_err_single", 64'(t_err), 64'd0);
      chk("to_stb_resume", 64'(i_stb), 64'd1);
      tick();
      quiet();
      tick();
      tick();

      // Ack arriving on the timeout cycle wins.
      set_port(0, 1, 1, 0, A0, 32'h0, 4'hF);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         if (i_stb) seen = 1'b1;
      end
      chk("ackto_stb_seen", 64'(seen), 64'd1);
      repeat (7) @(negedge clock);
      chk("ackto_no_early_err", 64'(t_err), 64'd0);
      tick();
      i_ack = 1'b1;
      @(negedge clock);
      chk("ackto_ack", 64'(t_ack), 64'b01);
      chk("ackto_err", 64'(t_err), 64'd0);
      tick();
      quiet();
      tick();
      tick();

      // Disabled timeout: a stuck strobe never errors.
      set_port(0, 1, 1, 0, A0, 32'h0, 4'hF);
      tick();
      tick();
      ez = 0;
      sz = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clock);
         if (t_err_z != 0) ez++;
         if (!i_stb_z) sz++;
      end
      chk("nt_err_count", 64'(ez), 64'd0);
      chk("nt_stb_low_count", 64'(sz), 64'd0);

      // Reset while initiator 1 owns the bus.
      set_port(1, 1, 1, 0, A1, 32'h0, 4'hF);
      tick();
      t_cyc[0] = 1'b0;
      t_stb[0] = 1'b0;
      tick();
      t_cyc[0] = 1'b1;
      t_stb[0] = 1'b1;
      i_ack    = 1'b1;
      tick();
      @(negedge clock);
      chk("mid_pre_adr", 64'(i_adr), 64'(A1));
      #2;
      reset = 1'b1;
      #1;
      chk("mid_i_cyc", 64'(i_cyc), 64'd0);
      chk("mid_i_stb", 64'(i_stb), 64'd0);
      chk("mid_t_ack", 64'(t_ack), 64'd0);
      chk("mid_t_err", 64'(t_err), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      @(negedge clock);
      chk("mid_regrant_adr", 64'(i_adr), 64'(A0));
      chk("mid_regrant_cyc", 64'(i_cyc), 64'd1);
      tick();
      quiet();
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int p = 0; p < N; p++) begin
            if (t_cyc[p]) begin
               if ($urandom_range(7) == 0) t_cyc[p] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               t_cyc[p] = 1'b1;
            end
            t_stb[p]            = t_cyc[p] && ($urandom_range(1) == 1);
            t_we[p]             = 1'($urandom_range(1));
            t_adr[p*AW +: AW]   = $urandom;
            t_dat_w[p*DW +: DW] = $urandom;
            t_sel[p*SW +: SW]   = 4'($urandom_range(15));
         end
         i_ack   = ($urandom_range(3) == 0);
         i_err   = ($urandom_range(15) == 0);
         i_dat_r = $urandom;
         reset   = ($urandom_range(499) == 0);
      end
      tick();
      reset = 1'b0;
      quiet();
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
